// File: rtl/ad_cal_pkg.sv
// Shared definitions for ADC lane DCO delay calibration.
package ad_cal_pkg;

  localparam int unsigned TAP_W           = 5;
  localparam int unsigned NUM_TAPS_DEF    = 32;
  localparam int unsigned SETTLE_CYC_DEF  = 16;
  localparam int unsigned SAMPLE_CYC_DEF  = 256;
  localparam int unsigned MIN_WIN_DEF     = 4;
  localparam int unsigned DEFAULT_TAP_DEF = 10;

  typedef enum logic [3:0] {
    StIdle,
    StWaitRdy,
    StLoad,
    StSettle,
    StSample,
    StNext,
    StApply,
    StVerify,
    StDone,
    StFail
  } cal_state_e;

endpackage

// File: rtl/dco_win_tracker.sv
// Online tracker of the current passing run and the widest run seen so far.
module dco_win_tracker
  import ad_cal_pkg::*;
(
  input  logic             dly_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] run_start_q, run_start_d, best_start_q, best_start_d;
  logic [TAP_W:0]   run_len_q, run_len_d, best_len_q, best_len_d;

  // Extend or break the current run, then promote it if strictly wider.
  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clear) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (step) begin
      if (pass) begin
        if (run_len_q == '0) run_start_d = tap;
        run_len_d = run_len_q + 1'b1;
      end else begin
        run_len_d = '0;
      end
      if (run_len_d > best_len_q) begin
        best_start_d = run_start_d;
        best_len_d   = run_len_d;
      end
    end
  end

  // Run/best state registers.
  always_ff @(posedge dly_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;

endmodule

// File: rtl/dco_tap_calib.sv
// Sweeps IDELAY taps, finds the widest passing window and loads its centre.
module dco_tap_calib
  import ad_cal_pkg::*;
#(
  parameter int unsigned NUM_TAPS    = NUM_TAPS_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned SAMPLE_CYC  = SAMPLE_CYC_DEF,
  parameter int unsigned MIN_WIN     = MIN_WIN_DEF,
  parameter int unsigned DEFAULT_TAP = DEFAULT_TAP_DEF
) (
  input  logic             dly_clk,
  input  logic             rst_n,
  input  logic             dly_rdy,
  input  logic             cal_start,
  input  logic             pattern_ok,
  input  logic [TAP_W-1:0] tap_rb,
  output logic [TAP_W-1:0] delay_tap,
  output logic             load_en,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] win_start,
  output logic [TAP_W:0]   win_len
);

  cal_state_e       state_q, state_d;
  logic             start_q;
  logic [TAP_W-1:0] tap_q, tap_d, dly_tap_q, dly_tap_d, target_q, target_d;
  logic [TAP_W-1:0] win_start_q, win_start_d, best_start;
  logic [TAP_W:0]   win_len_q, win_len_d, best_len, centre;
  logic [15:0]      cnt_q, cnt_d;
  logic             tap_bad_q, tap_bad_d, no_win_q, no_win_d;
  logic             done_q, done_d, fail_q, fail_d;
  logic             start_rise, trk_clear, trk_step;

  assign start_rise = cal_start & ~start_q;
  assign centre     = {1'b0, best_start} + (best_len >> 1);

  // Next-state, counters, strobe and result updates.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    cnt_d       = cnt_q;
    tap_bad_d   = tap_bad_q;
    dly_tap_d   = dly_tap_q;
    target_d    = target_q;
    no_win_d    = no_win_q;
    done_d      = done_q;
    fail_d      = fail_q;
    win_start_d = win_start_q;
    win_len_d   = win_len_q;
    load_en     = 1'b0;
    trk_clear   = 1'b0;
    trk_step    = 1'b0;
    cal_busy    = 1'b0;
    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start_rise) begin
          done_d      = 1'b0;
          fail_d      = 1'b0;
          win_start_d = '0;
          win_len_d   = '0;
          state_d     = StWaitRdy;
        end
      end
      StWaitRdy: begin
        cal_busy  = 1'b1;
        trk_clear = 1'b1;
        cnt_d     = '0;
        if (dly_rdy) begin
          tap_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cal_busy  = 1'b1;
        load_en   = 1'b1;
        dly_tap_d = tap_q;
        tap_bad_d = 1'b0;
        cnt_d     = '0;
        state_d   = StSettle;
      end
      StSettle: begin
        cal_busy = 1'b1;
        if (cnt_q == 16'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        // Full window is always sampled so per-tap time is constant.
        cal_busy  = 1'b1;
        tap_bad_d = tap_bad_q | ~pattern_ok;
        if (cnt_q == 16'(SAMPLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        cal_busy = 1'b1;
        trk_step = 1'b1;
        if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d = StApply;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = StLoad;
        end
      end
      StApply: begin
        cal_busy    = 1'b1;
        load_en     = 1'b1;
        no_win_d    = best_len < (TAP_W + 1)'(MIN_WIN);
        target_d    = no_win_d ? TAP_W'(DEFAULT_TAP) : centre[TAP_W-1:0];
        dly_tap_d   = target_d;
        win_start_d = best_start;
        win_len_d   = best_len;
        cnt_d       = '0;
        state_d     = StVerify;
      end
      StVerify: begin
        cal_busy = 1'b1;
        if (cnt_q == 16'd2) begin
          if (no_win_q || (tap_rb != target_q)) begin
            fail_d  = 1'b1;
            state_d = StFail;
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Losing the delay reference mid-sweep invalidates everything gathered so far.
    if (cal_busy && (state_q != StWaitRdy) && !dly_rdy) begin
      state_d     = StWaitRdy;
      load_en     = 1'b0;
      dly_tap_d   = dly_tap_q;
      win_start_d = win_start_q;
      win_len_d   = win_len_q;
      done_d      = done_q;
      fail_d      = fail_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge dly_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      tap_q       <= '0;
      cnt_q       <= '0;
      tap_bad_q   <= 1'b0;
      dly_tap_q   <= TAP_W'(DEFAULT_TAP);
      target_q    <= '0;
      no_win_q    <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      win_start_q <= '0;
      win_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= cal_start;
      tap_q       <= tap_d;
      cnt_q       <= cnt_d;
      tap_bad_q   <= tap_bad_d;
      dly_tap_q   <= dly_tap_d;
      target_q    <= target_d;
      no_win_q    <= no_win_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      win_start_q <= win_start_d;
      win_len_q   <= win_len_d;
    end
  end

  dco_win_tracker u_tracker (
    .dly_clk    (dly_clk),
    .rst_n      (rst_n),
    .clear      (trk_clear),
    .step       (trk_step),
    .pass       (~tap_bad_q),
    .tap        (tap_q),
    .best_start (best_start),
    .best_len   (best_len)
  );

  assign delay_tap = load_en ? dly_tap_d : dly_tap_q;
  assign cal_done  = done_q;
  assign cal_fail  = fail_q;
  assign win_start = win_start_q;
  assign win_len   = win_len_q;

endmodule
